// File: rtl/pipelined_control_unit.sv
// Single-slot pipelined instruction decoder with valid/ready handshakes and a multi-cycle mul hold.
// Optional build macro CU_FPU_EN enables decode of opcode 5 as FPU operations; otherwise opcode 5 is illegal.
module pipelined_control_unit #(
   parameter int IR_W    = 32,
   parameter int ALU_W   = 4,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ir_valid,
   input  logic [IR_W-1:0]  ir,
   output logic             ir_ready,
   input  logic             out_ready,
   output logic             ctl_valid,
   output logic             i_r,
   output logic             write_reg_en,
   output logic             regfile_src_oalu_st,
   output logic             jump,
   output logic             br_inst,
   output logic             wr_en_stk,
   output logic             illegal,
   output logic [ALU_W-1:0] ALU_inst
);

   // state     | meaning
   // S_EMPTY   | no instruction held, ready to accept
   // S_MULWAIT | mul accepted, counting down before controls are issued
   // S_FULL    | decoded controls presented downstream
   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_MULWAIT = 2'd1;
   localparam logic [1:0] S_FULL    = 2'd2;

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [10:0]      ctl_q;
   logic [10:0]      dec;
   logic [10:0]      ctl_out;
   logic             dec_mul;
   logic             xfer_in;

   logic [2:0] op;
   logic [1:0] fn;
   logic [3:0] d_alu;
   logic       d_ir, d_wr, d_rs, d_jmp, d_br, d_stk, d_ill;
   logic       unused_ir_bits;

   assign op = ir[IR_W-1 -: 3];
   assign fn = ir[IR_W-4 -: 2];
   assign unused_ir_bits = ^ir[IR_W-6:0];

   always_comb begin
      d_alu   = 4'd0;
      d_ir    = 1'b0;
      d_wr    = 1'b0;
      d_rs    = 1'b0;
      d_jmp   = 1'b0;
      d_br    = 1'b0;
      d_stk   = 1'b0;
      d_ill   = 1'b0;
      dec_mul = 1'b0;
      case (op)
         3'd0: begin
            d_wr = 1'b1;
            case (fn)
               2'd0: d_ir = 1'b1;
               2'd1: d_ir = 1'b0;
               2'd2: begin d_alu = 4'd1; d_ir = 1'b1; end
               default: begin d_alu = 4'd6; d_ir = 1'b1; dec_mul = 1'b1; end
            endcase
         end
         3'd1: begin
            case (fn)
               2'd0: begin d_wr = 1'b1; d_rs = 1'b1; end
               2'd1: d_stk = 1'b1;
               2'd2: d_wr = 1'b1;
               default: begin d_alu = 4'd2; d_ir = 1'b1; d_wr = 1'b1; end
            endcase
         end
         3'd2: begin
            d_br  = 1'b1;
            d_alu = 4'd2;
            d_ir  = 1'b1;
         end
         3'd3: d_jmp = 1'b1;
         3'd4: begin
            d_alu = 4'd3;
            d_ir  = 1'b1;
            d_wr  = 1'b1;
         end
         3'd5: begin
`ifdef CU_FPU_EN
            d_alu = 4'd11 + {2'b00, fn};
            d_ir  = 1'b1;
            d_wr  = 1'b1;
`else
            d_ill = 1'b1;
`endif
         end
         3'd6: begin
            d_alu = fn[0] ? 4'd5 : 4'd4;
            d_ir  = ~fn[1];
            d_wr  = 1'b1;
         end
         default: begin
            d_alu = 4'd7 + {2'b00, fn};
            d_wr  = 1'b1;
         end
      endcase
   end

   assign dec = {d_alu, d_ir, d_wr, d_rs, d_jmp, d_br, d_stk, d_ill};

   always_comb begin
      ir_ready = 1'b0;
      case (state)
         S_EMPTY: ir_ready = 1'b1;
         S_FULL:  ir_ready = out_ready;
         default: ir_ready = 1'b0;
      endcase
   end

   assign ctl_valid = (state == S_FULL);
   assign xfer_in   = ir_valid & ir_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
         cnt   <= '0;
         ctl_q <= '0;
      end else if (xfer_in) begin
         // In FULL, ir_ready implies out_ready, so an accept here is also a drain.
         ctl_q <= dec;
         if (dec_mul && (MUL_LAT > 1)) begin
            state <= S_MULWAIT;
            cnt   <= CNT_W'(MUL_LAT - 1);
         end else begin
            state <= S_FULL;
         end
      end else begin
         case (state)
            S_MULWAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= S_FULL;
            end
            S_FULL: if (out_ready) state <= S_EMPTY;
            S_EMPTY: state <= S_EMPTY;
            default: state <= S_EMPTY;
         endcase
      end
   end

   assign ctl_out = ctl_valid ? ctl_q : 11'd0;
   assign {i_r, write_reg_en, regfile_src_oalu_st, jump, br_inst, wr_en_stk, illegal} = ctl_out[6:0];
   assign ALU_inst = ALU_W'(ctl_out[10:7]);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit: per-cycle reference model comparison plus directed literal checks.
module tb_pipelined_control_unit;

   localparam int IR_W    = 32;
   localparam int ALU_W   = 4;
   localparam int MUL_LAT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ir_valid = 1'b0;
   logic [IR_W-1:0]  ir = '0;
   logic             ir_ready;
   logic             out_ready = 1'b0;
   logic             ctl_valid;
   logic             i_r, write_reg_en, regfile_src_oalu_st, jump, br_inst, wr_en_stk, illegal;
   logic [ALU_W-1:0] ALU_inst;

   int checks = 0;
   int errors = 0;

   pipelined_control_unit #(.IR_W(IR_W), .ALU_W(ALU_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
      .out_ready(out_ready), .ctl_valid(ctl_valid), .i_r(i_r), .write_reg_en(write_reg_en),
      .regfile_src_oalu_st(regfile_src_oalu_st), .jump(jump), .br_inst(br_inst),
      .wr_en_stk(wr_en_stk), .illegal(illegal), .ALU_inst(ALU_inst)
   );

   always #5 clk = ~clk;

   // Expected control word per {opcode,func}: {alu[3:0], i_r, wr, rsrc, jump, br, stk, illegal}
   logic [10:0] tbl [32];

   function automatic logic [10:0] pack(int alu, bit ir_b, bit wr, bit rs, bit jp, bit br, bit stk, bit ill);
      logic [3:0] a;
      a = 4'(alu);
      return {a, ir_b, wr, rs, jp, br, stk, ill};
   endfunction

   initial begin
      tbl[0]  = pack(0, 1, 1, 0, 0, 0, 0, 0);  // add
      tbl[1]  = pack(0, 0, 1, 0, 0, 0, 0, 0);  // addi
      tbl[2]  = pack(1, 1, 1, 0, 0, 0, 0, 0);  // addu
      tbl[3]  = pack(6, 1, 1, 0, 0, 0, 0, 0);  // mul
      tbl[4]  = pack(0, 0, 1, 1, 0, 0, 0, 0);  // lw
      tbl[5]  = pack(0, 0, 0, 0, 0, 0, 1, 0);  // sw
      tbl[6]  = pack(0, 0, 1, 0, 0, 0, 0, 0);  // lui
      tbl[7]  = pack(2, 1, 1, 0, 0, 0, 0, 0);  // sub
      for (int f = 0; f < 4; f++) begin
         tbl[8 + f]  = pack(2, 1, 0, 0, 0, 1, 0, 0);  // branch
         tbl[12 + f] = pack(0, 0, 0, 0, 1, 0, 0, 0);  // jump
         tbl[16 + f] = pack(3, 1, 1, 0, 0, 0, 0, 0);  // compare
`ifdef CU_FPU_EN
         tbl[20 + f] = pack(11 + f, 1, 1, 0, 0, 0, 0, 0);
`else
         tbl[20 + f] = pack(0, 0, 0, 0, 0, 0, 0, 1);
`endif
         tbl[28 + f] = pack(7 + f, 0, 1, 0, 0, 0, 0, 0);  // shift
      end
      tbl[24] = pack(4, 1, 1, 0, 0, 0, 0, 0);  // nand
      tbl[25] = pack(5, 1, 1, 0, 0, 0, 0, 0);  // nor
      tbl[26] = pack(4, 0, 1, 0, 0, 0, 0, 0);  // nandi
      tbl[27] = pack(5, 0, 1, 0, 0, 0, 0, 0);  // nori
   end

   // Model: one held instruction with a countdown until it becomes visible.
   bit          m_has = 0;
   int          m_wait = 0;
   logic [10:0] m_ctl = '0;

   function automatic bit exp_ready();
      return !m_has || (m_wait == 0 && out_ready);
   endfunction

   always @(posedge clk) begin
      bit rdy, vld;
      rdy = exp_ready();
      vld = m_has && (m_wait == 0);
      if (rst) begin
         m_has = 0;
         m_wait = 0;
      end else begin
         if (vld && out_ready) m_has = 0;
         else if (m_has && m_wait > 0) m_wait--;
         if (ir_valid && rdy) begin
            m_has  = 1;
            m_ctl  = tbl[ir[31:27]];
            m_wait = (ir[31:27] == 5'd3) ? MUL_LAT - 1 : 0;
         end
      end
   end

   function automatic logic [10:0] dut_ctl();
      return {ALU_inst[3:0], i_r, write_reg_en, regfile_src_oalu_st, jump, br_inst, wr_en_stk, illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      bit vld;
      vld = m_has && (m_wait == 0);
      check("model_ir_ready", 32'(ir_ready), 32'(exp_ready()));
      check("model_ctl_valid", 32'(ctl_valid), 32'(vld));
      check("model_ctl", 32'(dut_ctl()), vld ? 32'(m_ctl) : 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      check("reset_ir_ready", 32'(ir_ready), 32'd1);
      check("reset_ctl_valid", 32'(ctl_valid), 32'd0);
      check("reset_ctl", 32'(dut_ctl()), 32'd0);
      rst = 1'b0;

      // add: one-cycle latency
      ir = 32'h0000_0000; ir_valid = 1'b1; out_ready = 1'b1;
      step();
      ir_valid = 1'b0;
      check("add_valid", 32'(ctl_valid), 32'd1);
      check("add_alu", 32'(ALU_inst), 32'd0);
      check("add_i_r", 32'(i_r), 32'd1);
      check("add_wr", 32'(write_reg_en), 32'd1);
      step();
      check("add_drained", 32'(ctl_valid), 32'd0);

      // mul: two wait cycles then issue
      ir = 32'h1800_0000; ir_valid = 1'b1;
      step();
      ir_valid = 1'b0;
      check("mul_wait1_ready", 32'(ir_ready), 32'd0);
      check("mul_wait1_valid", 32'(ctl_valid), 32'd0);
      check("mul_wait1_alu", 32'(ALU_inst), 32'd0);
      step();
      check("mul_wait2_ready", 32'(ir_ready), 32'd0);
      check("mul_wait2_valid", 32'(ctl_valid), 32'd0);
      out_ready = 1'b0;
      step();
      check("mul_issue_valid", 32'(ctl_valid), 32'd1);
      check("mul_issue_alu", 32'(ALU_inst), 32'd6);

      // stall with a pending lw offered
      ir = 32'h2000_0000; ir_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", 32'(ctl_valid), 32'd1);
         check("stall_alu", 32'(ALU_inst), 32'd6);
         check("stall_ready", 32'(ir_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("release_ready", 32'(ir_ready), 32'd1);
      step();
      ir_valid = 1'b0;
      check("lw_after_stall_valid", 32'(ctl_valid), 32'd1);
      check("lw_after_stall_rsrc", 32'(regfile_src_oalu_st), 32'd1);
      check("lw_after_stall_alu", 32'(ALU_inst), 32'd0);
      step();

      // opcode 5
      ir = 32'hA000_0000; ir_valid = 1'b1;
      step();
      ir_valid = 1'b0;
`ifdef CU_FPU_EN
      check("op5_illegal", 32'(illegal), 32'd0);
      check("op5_alu", 32'(ALU_inst), 32'd11);
`else
      check("op5_illegal", 32'(illegal), 32'd1);
      check("op5_alu", 32'(ALU_inst), 32'd0);
      check("op5_wr", 32'(write_reg_en), 32'd0);
`endif
      step();

      // reset during MULWAIT
      ir = 32'h1800_0000; ir_valid = 1'b1;
      step();
      ir_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mulwait_valid", 32'(ctl_valid), 32'd0);
      check("rst_mulwait_ready", 32'(ir_ready), 32'd1);
      step();
      step();
      check("rst_mulwait_no_stale", 32'(ctl_valid), 32'd0);

      // reset dominates a coincident accept
      ir = 32'h0000_0000; ir_valid = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; ir_valid = 1'b0;
      check("rst_dominates_valid", 32'(ctl_valid), 32'd0);

      // back-to-back sw then lw
      ir = 32'h2800_0000; ir_valid = 1'b1;
      step();
      check("sw_stk", 32'(wr_en_stk), 32'd1);
      check("sw_wr", 32'(write_reg_en), 32'd0);
      ir = 32'h2000_0000;
      step();
      ir_valid = 1'b0;
      check("lw_rsrc", 32'(regfile_src_oalu_st), 32'd1);
      check("lw_stk", 32'(wr_en_stk), 32'd0);
      step();

      // sweep every opcode/func with a mixed back-pressure pattern
      for (int k = 0; k < 32; k++) begin
         ir = {5'(k), 27'h155_5555};
         ir_valid = 1'b1;
         out_ready = (k % 3) != 2;
         for (int w = 0; w < 8 && !(ir_valid && ir_ready); w++) step();
         check("sweep_accept", 32'(ir_valid && ir_ready), 32'd1);
         step();
      end
      ir_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
